cis_line_writer: RTL and testbench
==================================

// Module: cis_line_writer
// PURPOSE
//  Write side of the CIS scan line buffer. Takes the 8-bit CIS ADC pixel stream, drops the leading
//  dummy pixels after each line-start (SP) pulse, and writes 3*HoriPixNum samples (R,G,B segments)
//  linearly into RAM port A. Toggles the ping-pong bank bit per line and pulses wr_trigger per line.
//  Sits between the CIS AFE capture logic and the line-buffer read-address generator.
// PARAMETERS
//  ADDR_W  14  RAM address width; one bank holds 2**ADDR_W samples
//  DATA_W   8  pixel sample width
//  SKIP_W  16  width of the dummy-pixel skip count
// PORTS
//  clk         in   1        system clock; single clock domain
//  rst_n       in   1        asynchronous active-low reset
//  line_start  in   1        1-cycle SP pulse; starts a line
//  pix_valid   in   1        pix_data valid this cycle; may have arbitrary gaps
//  pix_data    in   DATA_W   pixel sample
//  HoriPixNum  in   13       pixels per colour segment; sampled at line_start
//  skip_num    in   SKIP_W   dummy pixels dropped after SP; sampled at line_start
//  wea         out  1        RAM write enable
//  addra       out  ADDR_W   RAM write address
//  dina        out  DATA_W   RAM write data
//  bank_sel    out  1        ping-pong bank being written (feeds reader CSEN)
//  wr_trigger  out  1        1-cycle pulse: line complete in bank ~bank_sel
//  line_err    out  1        1-cycle pulse: SP arrived mid-line (line aborted)
//  cfg_err     out  1        sticky: HoriPixNum invalid at last line_start
// BEHAVIOUR
//  Reset: all outputs 0, FSM=WAIT_SP, counters 0. Reset mid-line discards the line, no trigger.
//  FSM: WAIT_SP -> (line_start & cfg ok) SKIP -> (skip_cnt==skip_num_q) WRITE -> (last write) DONE
//       -> WAIT_SP. skip_num_q==0: SKIP falls through in one cycle, no pixel lost.
//  line_start latches HoriPixNum_q/skip_num_q; last_addr = 3*HoriPixNum_q-1 computed in 16 bits.
//  cfg check: HoriPixNum==0 or last_addr>2**ADDR_W-1 -> cfg_err=1, stay WAIT_SP; a valid
//   line_start clears cfg_err.
//  SKIP: each pix_valid increments skip_cnt; samples are discarded.
//  WRITE: each pix_valid -> next cycle wea=1, addra=addr, dina=pix_data (latency 1, registered);
//   addr starts 0 and increments by 1; pix_valid low -> wea=0, addr holds.
//  Write with addr==last_addr -> DONE. DONE (1 cycle): wr_trigger=1, bank_sel toggles,
//   addr/skip_cnt cleared. wr_trigger coincides with bank_sel toggle, 1 cycle after last wea.
//  line_start in SKIP/WRITE: line_err=1 same cycle as next state; abort, no trigger, no bank
//   toggle; new line restarts immediately (re-latch, addr=0).
//  line_start in DONE: honoured next cycle (held in a 1-bit pending flag).
//  pix_valid in WAIT_SP/DONE: ignored.
//  line_start with pix_valid same cycle: that pixel counts as the first SKIP pixel.
// CONFIGURATION
//  CIS_LINE_WRITER_TEST_PATTERN_EN defined: dina = addr[DATA_W-1:0] (ramp), pix_data ignored;
//   timing unchanged. Not defined: dina = pix_data.
// STRUCTURE
//  Shared package cis_scan_pkg: FSM state encoding, ADDR_W/DATA_W defaults, colour-count constant 3.
//  No sub-module; single FSM + skip counter + address counter + output registers.
// TESTING
//  N=432, skip=0, continuous valid -> 1296 wea, addra 0..1295, wr_trigger 1 cycle after addra=1295.
//  N=432, skip=3, valid 50% duty -> first 3 samples dropped, dina@addra0 = 4th sample.
//  Two lines back-to-back -> bank_sel 0->1->0, one wr_trigger per line, never with wea on same addr.
//  line_start at addra=500 -> line_err pulse, no wr_trigger, addra restarts at 0 with same bank_sel.
//  HoriPixNum=0 then 5462 -> cfg_err set, no wea; HoriPixNum=5461 -> cfg_err clears, last addra=16382.
//  rst_n low at addra=700 -> all outputs 0 async; post-reset line_start -> normal line in bank 0.

Source files
------------

// File: rtl/cis_scan_pkg.sv
// Shared definitions for the CIS scan line buffer: parameter defaults,
// colour-segment count and the line-writer FSM state type.
package cis_scan_pkg;

  localparam int unsigned CIS_ADDR_W  = 14;
  localparam int unsigned CIS_DATA_W  = 8;
  localparam int unsigned CIS_SKIP_W  = 16;
  localparam int unsigned CIS_COLOURS = 3;
  localparam int unsigned CIS_LAST_W  = 16;

  typedef enum logic [1:0] {
    ST_WAIT_SP,
    ST_SKIP,
    ST_WRITE,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/cis_line_writer_if.sv
// Pixel stream in / RAM port A out of the CIS line writer.
// master drives the pixel stream and observes the RAM port; slave is the writer.
interface cis_line_writer_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
);
  logic              line_start;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;

  modport master (
    output line_start, pix_valid, pix_data,
    input  wea, addra, dina
  );

  modport slave (
    input  line_start, pix_valid, pix_data,
    output wea, addra, dina
  );
endinterface

// File: rtl/cis_line_writer.sv
// CIS scan line buffer write side: drops dummy pixels after SP, writes 3*HoriPixNum samples to RAM A.
// Optional build macro CIS_LINE_WRITER_TEST_PATTERN_EN replaces dina with an address ramp.
module cis_line_writer
  import cis_scan_pkg::*;
#(
  parameter int unsigned ADDR_W = CIS_ADDR_W,
  parameter int unsigned DATA_W = CIS_DATA_W,
  parameter int unsigned SKIP_W = CIS_SKIP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  cis_line_writer_if.slave   bus,
  input  logic [12:0]        HoriPixNum,
  input  logic [SKIP_W-1:0]  skip_num,
  output logic               bank_sel,
  output logic               wr_trigger,
  output logic               line_err,
  output logic               cfg_err
);

  localparam logic [31:0] ADDR_MAX = (32'd1 << ADDR_W) - 32'd1;

  wr_state_e           state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   last_q;
  logic [SKIP_W-1:0]   skip_q;
  logic [SKIP_W-1:0]   skip_cnt;
  logic                pend;

  logic [CIS_LAST_W-1:0] last_calc;
  logic                  cfg_ok;
  logic                  restart;
  logic                  last_hit;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W-1:0]     first_data;

  always_comb begin
    last_calc = CIS_LAST_W'(CIS_LAST_W'(HoriPixNum) * CIS_LAST_W'(CIS_COLOURS)) - CIS_LAST_W'(1);
    cfg_ok    = (HoriPixNum != '0) && (32'(last_calc) <= ADDR_MAX);
    // A pending SP from DONE starts the line from WAIT_SP; SP in SKIP/WRITE aborts and restarts.
    if (state == ST_WAIT_SP)
      restart = bus.line_start | pend;
    else
      restart = bus.line_start && (state == ST_SKIP || state == ST_WRITE);
    last_hit = (addr == last_q);
`ifdef CIS_LINE_WRITER_TEST_PATTERN_EN
    wr_data    = addr[DATA_W-1:0];
    first_data = '0;
`else
    wr_data    = bus.pix_data;
    first_data = bus.pix_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT_SP;
      addr       <= '0;
      last_q     <= '0;
      skip_q     <= '0;
      skip_cnt   <= '0;
      pend       <= 1'b0;
      bus.wea    <= 1'b0;
      bus.addra  <= '0;
      bus.dina   <= '0;
      bank_sel   <= 1'b0;
      wr_trigger <= 1'b0;
      line_err   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      bus.wea    <= 1'b0;
      wr_trigger <= 1'b0;
      line_err   <= 1'b0;
      if (restart) begin
        pend     <= 1'b0;
        line_err <= (state != ST_WAIT_SP);
        addr     <= '0;
        skip_cnt <= '0;
        if (!cfg_ok) begin
          cfg_err <= 1'b1;
          state   <= ST_WAIT_SP;
        end else begin
          cfg_err <= 1'b0;
          last_q  <= ADDR_W'(last_calc);
          skip_q  <= skip_num;
          state   <= ST_SKIP;
          // The pixel coinciding with SP is the first pixel of the line.
          if (bus.pix_valid) begin
            if (skip_num == '0) begin
              bus.wea   <= 1'b1;
              bus.addra <= '0;
              bus.dina  <= first_data;
              addr      <= ADDR_W'(1);
              state     <= ST_WRITE;
            end else begin
              skip_cnt <= SKIP_W'(1);
            end
          end
        end
      end else begin
        case (state)
          ST_SKIP, ST_WRITE: begin
            if (state == ST_SKIP && skip_cnt != skip_q) begin
              if (bus.pix_valid) skip_cnt <= skip_cnt + SKIP_W'(1);
            end else begin
              // Skip satisfied: this cycle already behaves as WRITE so no pixel is lost.
              state <= ST_WRITE;
              if (bus.pix_valid) begin
                bus.wea   <= 1'b1;
                bus.addra <= addr;
                bus.dina  <= wr_data;
                if (last_hit) state <= ST_DONE;
                else          addr  <= addr + ADDR_W'(1);
              end
            end
          end
          ST_DONE: begin
            wr_trigger <= 1'b1;
            bank_sel   <= ~bank_sel;
            addr       <= '0;
            skip_cnt   <= '0;
            pend       <= bus.line_start;
            state      <= ST_WAIT_SP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cis_line_writer.sv
// Self-checking bench for cis_line_writer: randomized pixel streams against a line-level write model.
module tb_cis_line_writer;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [12:0]   hori;
  logic [SW-1:0] skip;
  logic          bank_sel, wr_trigger, line_err, cfg_err;

  cis_line_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cis_line_writer #(.ADDR_W(AW), .DATA_W(DW), .SKIP_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .HoriPixNum (hori),
    .skip_num   (skip),
    .bank_sel   (bank_sel),
    .wr_trigger (wr_trigger),
    .line_err   (line_err),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed RAM writes and event counters
  logic [31:0] act_q[$];
  int trig_cnt = 0, trig_cyc = 0, last_wea_cyc = 0, trig_wea = 0, lerr_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wea) begin
        act_q.push_back({10'd0, bus.addra, bus.dina});
        last_wea_cyc = cyc;
      end
      if (wr_trigger) begin
        trig_cnt++;
        trig_cyc = cyc;
        if (bus.wea) trig_wea++;
      end
      if (line_err) lerr_cnt++;
    end
  end

  logic [31:0] exp_q[$];
  logic [7:0]  samp_q[$];
  int ai = 0, ei = 0;
  int passed = 0, fails = 0, total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int a, input logic [7:0] d);
    logic [13:0] a14;
    logic [7:0]  ed;
    a14 = a[13:0];
`ifdef CIS_LINE_WRITER_TEST_PATTERN_EN
    ed = a14[7:0];
`else
    ed = d;
`endif
    return {10'd0, a14, ed};
  endfunction

  // Every valid pixel from SP on is numbered k; pixels skip..skip+3n-1 land at address k-skip.
  task automatic drive_line(input int n, input int sk, input int duty, input int npix, input bit coincide);
    int k = 0;
    bit v;
    logic [7:0] d;
    samp_q.delete();
    hori = 13'(n);
    skip = SW'(sk);
    v = coincide;
    d = 8'($urandom);
    bus.line_start = 1'b1;
    bus.pix_valid  = v;
    bus.pix_data   = d;
    if (v) begin
      samp_q.push_back(d);
      if (k >= sk && k < sk + 3 * n) exp_q.push_back(pack(k - sk, d));
      k++;
    end
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    while (k < npix) begin
      v = ($urandom_range(0, 99) < duty);
      d = 8'($urandom);
      bus.pix_valid = v;
      bus.pix_data  = d;
      if (v) begin
        samp_q.push_back(d);
        if (k >= sk && k < sk + 3 * n) exp_q.push_back(pack(k - sk, d));
        k++;
      end
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_trig(input string tag, input int target);
    int n = 0;
    while (trig_cnt < target && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_trig_cnt"}, trig_cnt, target);
  endtask

  task automatic check_writes(input string tag);
    int na, ne, mism;
    na = act_q.size() - ai;
    ne = exp_q.size() - ei;
    mism = 0;
    check({tag, "_nwrites"}, na, ne);
    for (int i = 0; i < na && i < ne; i++)
      if (act_q[ai + i] !== exp_q[ei + i]) mism++;
    check({tag, "_write_mismatches"}, mism, 0);
    ai = act_q.size();
    ei = exp_q.size();
  endtask

  task automatic cfg_pulse(input int n);
    hori = 13'(n);
    skip = '0;
    bus.line_start = 1'b1;
    bus.pix_valid  = 1'b1;
    bus.pix_data   = 8'($urandom);
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    repeat (10) begin
      bus.pix_data = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b0;
    int          t0, l0, c0, s0;
    logic [31:0] w;

    bus.line_start = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    hori = '0;
    skip = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_wea", bus.wea, 0);
    check("rst_addra", bus.addra, 0);
    check("rst_dina", bus.dina, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_wr_trigger", wr_trigger, 0);
    check("rst_line_err", line_err, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;

    // N=432, no skip, continuous valid
    b0 = bank_sel; t0 = trig_cnt;
    drive_line(432, 0, 100, 1296, 0);
    wait_trig("l1", t0 + 1);
    check_writes("l1");
    w = act_q[act_q.size() - 1];
    check("l1_last_addra", w[21:8], 1295);
    check("l1_trig_latency", trig_cyc - last_wea_cyc, 1);
    check("l1_bank_sel", bank_sel, !b0);

    // N=432, skip 3, 50% duty, pixel coincident with SP
    b0 = bank_sel; t0 = trig_cnt; s0 = act_q.size();
    drive_line(432, 3, 50, 1299, 1);
    wait_trig("l2", t0 + 1);
    w = act_q[s0];
    check("l2_first_write", w, pack(0, samp_q[3]));
    check_writes("l2");
    check("l2_bank_sel", bank_sel, !b0);

    // back-to-back lines: second SP lands in the DONE cycle
    b0 = bank_sel; t0 = trig_cnt;
    drive_line(20, 1, 70, 61, 0);
    drive_line(20, 1, 70, 61, 0);
    wait_trig("b2b", t0 + 2);
    check_writes("b2b");
    check("b2b_bank_sel", bank_sel, b0);

    // SP mid-line at addra=500 aborts and restarts
    b0 = bank_sel; t0 = trig_cnt; l0 = lerr_cnt;
    drive_line(432, 0, 100, 501, 0);
    drive_line(432, 0, 100, 1296, 0);
    wait_trig("abort", t0 + 1);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_extra_trig", trig_cnt, t0 + 1);
    check("abort_line_err", lerr_cnt, l0 + 1);
    check_writes("abort");
    check("abort_bank_sel", bank_sel, !b0);

    // invalid configurations
    c0 = act_q.size();
    cfg_pulse(0);
    @(negedge clk);
    check("cfg0_err", cfg_err, 1);
    check("cfg0_no_writes", act_q.size(), c0);
    @(posedge clk); #1;
    cfg_pulse(5462);
    @(negedge clk);
    check("cfg5462_err", cfg_err, 1);
    check("cfg5462_no_writes", act_q.size(), c0);
    @(posedge clk); #1;
    b0 = bank_sel; t0 = trig_cnt;
    drive_line(5461, 2, 100, 16385, 0);
    check("cfg5461_err_clear", cfg_err, 0);
    wait_trig("cfg5461", t0 + 1);
    w = act_q[act_q.size() - 1];
    check("cfg5461_last_addra", w[21:8], 16382);
    check_writes("cfg5461");
    check("cfg5461_bank_sel", bank_sel, !b0);

    // async reset while addra=700 is on the port
    t0 = trig_cnt;
    drive_line(432, 0, 100, 701, 0);
    #1 rst_n = 1'b0;
    #1;
    // the addra=700 write is cleared by reset before the monitor samples it
    void'(exp_q.pop_back());
    check("arst_wea", bus.wea, 0);
    check("arst_addra", bus.addra, 0);
    check("arst_dina", bus.dina, 0);
    check("arst_bank_sel", bank_sel, 0);
    check("arst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_no_trig", trig_cnt, t0);
    drive_line(432, 0, 100, 1296, 0);
    wait_trig("post_rst", t0 + 1);
    check_writes("post_rst");
    check("post_rst_bank_sel", bank_sel, 1);
    check("trig_with_wea", trig_wea, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
